// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared opcode constants, address type and branch-offset
//                helper for the fetch front-end.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef logic [31:0] addr_t;

    localparam logic [5:0] OPC_BEQ = 6'b000100;
    localparam logic [5:0] OPC_J   = 6'b000010;

    // Word offset of a beq: sign-extended immediate shifted left by two.
    function automatic addr_t br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/if_next_pc_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_next_pc_gen_if
//  Description : Fetch-stage bundle between the IF PC generator, the imem,
//                the ID-stage branch predictor and the hazard unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_next_pc_gen_if
    import mips_pkg::*;
#(
    parameter int BHT_IDX_W = 5,
    parameter int CNT_W     = 16
);
    logic [31:0]          instr_IF;
    logic                 br_prediction;
    logic                 stall;
    logic                 flush;
    addr_t                pc_IF;
    addr_t                pc_plus4_IF;
    logic [BHT_IDX_W-1:0] branch_addr_lw_5b;
    logic                 ifid_flush;
    logic [CNT_W-1:0]     mispred_cnt;
    logic                 recov_err;

    // PC generator side
    modport slave (
        input  instr_IF, br_prediction, stall, flush,
        output pc_IF, pc_plus4_IF, branch_addr_lw_5b, ifid_flush,
               mispred_cnt, recov_err
    );

    // Surrounding pipeline side
    modport master (
        output instr_IF, br_prediction, stall, flush,
        input  pc_IF, pc_plus4_IF, branch_addr_lw_5b, ifid_flush,
               mispred_cnt, recov_err
    );
endinterface : if_next_pc_gen_if
`default_nettype wire

// File: rtl/if_br_target_calc.sv
`default_nettype none
// ============================================================================
//  Module      : if_br_target_calc
//  Description : Combinational decode of beq/j and their target addresses
//                from the word fetched this cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_br_target_calc
    import mips_pkg::*;
(
    input  wire logic [31:0] instr_IF,
    input  wire addr_t       pc_plus4,
    output addr_t            br_tgt,
    output addr_t            j_tgt,
    output logic             is_beq,
    output logic             is_j
);

    // Opcode decode and both candidate targets, all mod 2^32.
    always_comb begin
        is_beq = (instr_IF[31:26] == OPC_BEQ);
        is_j   = (instr_IF[31:26] == OPC_J);
        br_tgt = pc_plus4 + br_offset(instr_IF[15:0]);
        j_tgt  = {pc_plus4[31:28], instr_IF[25:0], 2'b00};
    end

endmodule : if_br_target_calc
`default_nettype wire

// File: rtl/if_next_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : if_next_pc_gen
//  Description : IF-stage PC register with beq/j steering, not-chosen-path
//                recording for mispredict recovery, BHT index output and a
//                saturating mispredict counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_next_pc_gen
    import mips_pkg::*;
#(
    parameter addr_t RESET_PC  = 32'h0040_0000,
    parameter int    BHT_IDX_W = 5,
    parameter int    CNT_W     = 16
)(
    input  wire logic        clk,
    input  wire logic        rst_n,
    if_next_pc_gen_if.slave  bus
);

    addr_t            pc_q, pc_d;
    addr_t            alt_pc_q, alt_pc_d;
    logic             alt_valid_q, alt_valid_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
    logic             recov_err_q, recov_err_d;

    addr_t            pc_plus4;
    addr_t            br_tgt;
    addr_t            j_tgt;
    logic             is_beq;
    logic             is_j;

    assign pc_plus4 = pc_q + 32'd4;

    if_br_target_calc u_tgt (
        .instr_IF (bus.instr_IF),
        .pc_plus4 (pc_plus4),
        .br_tgt   (br_tgt),
        .j_tgt    (j_tgt),
        .is_beq   (is_beq),
        .is_j     (is_j)
    );

    // Next-state selection: stall freezes everything (including a stray
    // flush); a flush returns to the recorded path and discards the IF word.
    always_comb begin
        pc_d          = pc_q;
        alt_pc_d      = alt_pc_q;
        alt_valid_d   = alt_valid_q;
        mispred_cnt_d = mispred_cnt_q;
        recov_err_d   = recov_err_q;
        if (!bus.stall) begin
            if (bus.flush) begin
                pc_d        = alt_pc_q;
                alt_valid_d = 1'b0;
                if (mispred_cnt_q != {CNT_W{1'b1}}) begin
                    mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
                end
                if (!alt_valid_q) begin
                    recov_err_d = 1'b1;
                end
            end else if (is_j) begin
                pc_d        = j_tgt;
                alt_valid_d = 1'b0;
            end else if (is_beq) begin
                pc_d        = bus.br_prediction ? br_tgt   : pc_plus4;
                alt_pc_d    = bus.br_prediction ? pc_plus4 : br_tgt;
                alt_valid_d = 1'b1;
            end else begin
                pc_d        = pc_plus4;
                alt_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            alt_pc_q      <= '0;
            alt_valid_q   <= 1'b0;
            mispred_cnt_q <= '0;
            recov_err_q   <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            alt_pc_q      <= alt_pc_d;
            alt_valid_q   <= alt_valid_d;
            mispred_cnt_q <= mispred_cnt_d;
            recov_err_q   <= recov_err_d;
        end
    end

    assign bus.pc_IF             = pc_q;
    assign bus.pc_plus4_IF       = pc_plus4;
    assign bus.branch_addr_lw_5b = pc_q[2 +: BHT_IDX_W];
    assign bus.ifid_flush        = bus.flush & ~bus.stall;
    assign bus.mispred_cnt       = mispred_cnt_q;
    assign bus.recov_err         = recov_err_q;

endmodule : if_next_pc_gen
`default_nettype wire

// File: tb/tb_if_next_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_next_pc_gen
//  Description : Directed vector bench for if_next_pc_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_next_pc_gen;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    typedef struct {
        logic [31:0] instr;
        logic        pred;
        logic        stall;
        logic        flush;
        logic        exp_ifid;
        logic [31:0] exp_pc;
        logic [15:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    if_next_pc_gen_if #(.BHT_IDX_W(5), .CNT_W(16)) bus ();

    if_next_pc_gen #(
        .RESET_PC  (RST_PC),
        .BHT_IDX_W (5),
        .CNT_W     (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Check registered outputs after an edge, plus derived PC outputs.
    task automatic chk_state(input string tag, input logic [31:0] pc,
                             input logic [15:0] cnt, input logic err);
        logic [31:0] pp4;
        pp4 = pc + 32'd4;
        chk({tag, ".pc"},   bus.pc_IF, pc);
        chk({tag, ".cnt"},  {16'h0, bus.mispred_cnt}, {16'h0, cnt});
        chk({tag, ".err"},  {31'h0, bus.recov_err}, {31'h0, err});
        chk({tag, ".pp4"},  bus.pc_plus4_IF, pp4);
        chk({tag, ".bht"},  {27'h0, bus.branch_addr_lw_5b}, {27'h0, pc[6:2]});
    endtask

    task automatic drive(input logic [31:0] instr, input logic pred,
                         input logic stall, input logic flush);
        bus.instr_IF      = instr;
        bus.br_prediction = pred;
        bus.stall         = stall;
        bus.flush         = flush;
    endtask

    task automatic apply(input vec_t v, input string tag);
        drive(v.instr, v.pred, v.stall, v.flush);
        #3;
        chk({tag, ".ifid"}, {31'h0, bus.ifid_flush}, {31'h0, v.exp_ifid});
        @(posedge clk);
        #1;
        chk_state(tag, v.exp_pc, v.exp_cnt, v.exp_err);
    endtask

    function automatic logic [31:0] beq(input logic [15:0] imm);
        return {6'b000100, 10'h0, imm};
    endfunction

    function automatic logic [31:0] jmp(input logic [25:0] idx);
        return {6'b000010, idx};
    endfunction

    initial begin
        //                instr             pred  stl   fls   ifid  pc            cnt  err
        vecs.push_back('{NOP,               1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0004, 16'd0, 1'b0});
        vecs.push_back('{NOP,               1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0008, 16'd0, 1'b0});
        vecs.push_back('{NOP,               1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_000C, 16'd0, 1'b0});
        vecs.push_back('{NOP,               1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0010, 16'd0, 1'b0});
        // beq taken-predicted, then mispredict back to fall-through
        vecs.push_back('{beq(16'h0003),     1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0020, 16'd0, 1'b0});
        vecs.push_back('{NOP,               1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0014, 16'd1, 1'b0});
        vecs.push_back('{jmp(26'h010_0010), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0040, 16'd1, 1'b0});
        // backward beq not-taken-predicted, then mispredict to target
        vecs.push_back('{beq(16'hFFFE),     1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0044, 16'd1, 1'b0});
        vecs.push_back('{NOP,               1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_003C, 16'd2, 1'b0});
        // beq then 3 stalls with another beq on the bus: alt must not change
        vecs.push_back('{beq(16'h0004),     1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0050, 16'd2, 1'b0});
        vecs.push_back('{beq(16'h0007),     1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0050, 16'd2, 1'b0});
        vecs.push_back('{beq(16'h0007),     1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0050, 16'd2, 1'b0});
        vecs.push_back('{beq(16'h0007),     1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0050, 16'd2, 1'b0});
        vecs.push_back('{NOP,               1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0040, 16'd3, 1'b0});
        // stall & flush together: everything ignored, including the error flag
        vecs.push_back('{NOP,               1'b0, 1'b1, 1'b1, 1'b0, 32'h0040_0040, 16'd3, 1'b0});
        vecs.push_back('{NOP,               1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0044, 16'd3, 1'b0});
        vecs.push_back('{NOP,               1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0048, 16'd3, 1'b0});
        vecs.push_back('{NOP,               1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_004C, 16'd3, 1'b0});
        vecs.push_back('{NOP,               1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0050, 16'd3, 1'b0});
        // j with no bubble, then flush with no recorded path (alt still 0x400040)
        vecs.push_back('{jmp(26'h010_0008), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0020, 16'd3, 1'b0});
        vecs.push_back('{NOP,               1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0040, 16'd4, 1'b1});
        // zero-offset beq: alt equals chosen path
        vecs.push_back('{beq(16'h0000),     1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0044, 16'd4, 1'b1});
        vecs.push_back('{NOP,               1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0044, 16'd5, 1'b1});
        // back-to-back beqs: flush refers to the second
        vecs.push_back('{beq(16'h0001),     1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0048, 16'd5, 1'b1});
        vecs.push_back('{beq(16'h0002),     1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_004C, 16'd5, 1'b1});
        vecs.push_back('{NOP,               1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0054, 16'd6, 1'b1});

        // reset state
        drive(NOP, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", RST_PC, 16'd0, 1'b0);
        chk("reset.ifid", {31'h0, bus.ifid_flush}, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        // counter saturation: flush every cycle until 0xFFFE (pc stays at 0x400054)
        drive(NOP, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16'hFFFE - 6; i++) begin
            @(posedge clk);
        end
        #1;
        chk_state("sat.fffe", 32'h0040_0054, 16'hFFFE, 1'b1);
        @(posedge clk); #1;
        chk_state("sat.ffff", 32'h0040_0054, 16'hFFFF, 1'b1);
        @(posedge clk); #1;
        chk_state("sat.hold", 32'h0040_0054, 16'hFFFF, 1'b1);

        // mid-run reset with a beq in flight; later flush has no recovery
        drive(beq(16'h0010), 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_state("inflight", 32'h0040_0098, 16'hFFFF, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_state("midrst", RST_PC, 16'd0, 1'b0);
        rst_n = 1'b1;
        drive(NOP, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk_state("postrst", 32'h0000_0000, 16'd1, 1'b1);
        drive(NOP, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_if_next_pc_gen
`default_nettype wire
